core_mem_port: RTL and testbench
================================

// Module: core_mem_port
// PURPOSE
//  Memory-side partner of the core register file. Takes the RF read-only address/data words (ROA/ROD) plus a
//  request strobe, runs one bus transaction (valid/ready request, rvalid response), and returns load data on
//  main_o, which drives the RF core-read input. One transaction in flight; sits between RF and the memory bus.
// PARAMETERS
//  WORD_WIDTH      16   width of core words (ROA/ROD/main) and of bus data
//  ADDRESS_WIDTH   16   bus address width; must be <= WORD_WIDTH; bus_addr_o = roa_i[ADDRESS_WIDTH-1:0]
//  TIMEOUT_CYCLES  255  max cycles spent in REQ+WAIT before abort (used only with CORE_MEM_TIMEOUT_EN); >= 2
// PORTS
//  clk_i        in   1              clock, all state on rising edge
//  arst_n_i     in   1              asynchronous reset, active low
//  req_i        in   1              core requests a transaction (sampled only in IDLE)
//  we_i         in   1              1 = store, 0 = load
//  roa_i        in   WORD_WIDTH     address word from RF ROA output
//  rod_i        in   WORD_WIDTH     store data word from RF ROD output
//  busy_o       out  1              transaction in progress (state != IDLE)
//  done_o       out  1              one-cycle pulse: transaction finished
//  err_o        out  1              one-cycle pulse with done_o: transaction aborted by timeout
//  main_o       out  WORD_WIDTH     last load data; drives RF main_input_i
//  bus_valid_o  out  1              request valid
//  bus_ready_i  in   1              bus accepts request
//  bus_we_o     out  1              request is a write
//  bus_addr_o   out  ADDRESS_WIDTH  request address
//  bus_wdata_o  out  WORD_WIDTH     write data
//  bus_rvalid_i in   1              read data valid
//  bus_rdata_i  in   WORD_WIDTH     read data
// BEHAVIOUR
//  - Reset (async, arst_n_i=0): state IDLE; all outputs 0, incl. main_o, bus_valid_o, captured addr/data/we.
//    Reset mid-transaction drops bus_valid_o immediately; no done_o is generated for the killed transaction.
//  - FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE; all outputs registered or decoded from state/capture regs.
//  - IDLE: if req_i, capture roa_i[ADDRESS_WIDTH-1:0], rod_i, we_i; next state REQ. Else stay.
//  - REQ: bus_valid_o=1 with captured addr/wdata/we held stable until handshake (bus_valid_o & bus_ready_i).
//    On handshake: store -> DONE; load -> WAIT.
//  - WAIT: on bus_rvalid_i, main_o <= bus_rdata_i, -> DONE. rvalid is ignored in every other state
//    (incl. the REQ handshake cycle); earliest accepted rvalid is the cycle after the handshake.
//  - DONE: done_o=1 for exactly this cycle; -> IDLE. req_i in DONE is ignored; a new request is sampled in IDLE.
//  - busy_o = 1 in REQ, WAIT, DONE. req_i while busy is ignored (not queued).
//  - main_o changes only on a completed load; stores and aborted loads leave it unchanged.
//  - Latency (req_i at cycle 0): bus_valid_o at 1; store with ready at 1 -> done_o at 2;
//    load with ready at 1, rvalid at 2 -> main_o valid and done_o at 3. Back-to-back: next req_i at 3 earliest.
// CONFIGURATION
//  CORE_MEM_TIMEOUT_EN defined: counter cleared on leaving IDLE, increments each cycle in REQ and WAIT; when it
//   reaches TIMEOUT_CYCLES without completing, bus_valid_o drops, -> DONE with done_o=1 and err_o=1;
//   main_o unchanged. A handshake/rvalid in the cycle the counter reaches the limit wins (normal completion).
//  Not defined: no counter; REQ/WAIT wait indefinitely; err_o tied to 0; TIMEOUT_CYCLES unused.
// TESTING
//  1 Reset: arst_n_i=0 mid-load in WAIT -> all outputs 0 same cycle; after release, IDLE, no done_o.
//  2 Store: req_i=1,we_i=1,roa=0x0040,rod=0xBEEF, ready=1 -> bus_valid_o at cyc1 addr 0x0040 wdata 0xBEEF, done_o cyc2.
//  3 Load with stall: roa=0x0123, ready low 3 cycles, rvalid 2 cycles later with 0x5A5A -> addr held stable
//    while stalled; main_o=0x5A5A coincident with done_o; busy_o high throughout.
//  4 rvalid=1 in REQ handshake cycle with 0x1111, then rvalid next cycle with 0x2222 -> main_o=0x2222.
//  5 req_i held high continuously for 3 stores -> exactly one transaction per IDLE visit, done_o every 3 cycles.
//  6 CORE_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready never asserted -> bus_valid_o drops after 8 REQ cycles,
//    done_o=err_o=1 one cycle, main_o unchanged; without macro -> bus_valid_o stays high, err_o never 1.

Source files
------------

// File: rtl/core_mem_port.sv
// Memory-side port for the core register file: one bus transaction per request, load data returned on main_o.
// Optional abort-on-timeout is enabled by defining CORE_MEM_TIMEOUT_EN.
module core_mem_port #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [WORD_WIDTH-1:0]    roa_i,
  input  logic [WORD_WIDTH-1:0]    rod_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [WORD_WIDTH-1:0]    main_o,
  output logic                     bus_valid_o,
  input  logic                     bus_ready_i,
  output logic                     bus_we_o,
  output logic [ADDRESS_WIDTH-1:0] bus_addr_o,
  output logic [WORD_WIDTH-1:0]    bus_wdata_o,
  input  logic                     bus_rvalid_i,
  input  logic [WORD_WIDTH-1:0]    bus_rdata_i
);

  if (ADDRESS_WIDTH > WORD_WIDTH || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("core_mem_port: ADDRESS_WIDTH must be <= WORD_WIDTH and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0]    wdata_q;
  logic [WORD_WIDTH-1:0]    main_q;
  logic                     we_q;
  logic                     abort;

`ifdef CORE_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // A handshake or rvalid in the limit cycle takes priority over the abort; a load
  // that handshakes on the limit still aborts on its first WAIT cycle without rvalid.
  always_comb begin
    abort = 1'b0;
    if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
      abort = ((state == S_REQ) && !bus_ready_i) || ((state == S_WAIT) && !bus_rvalid_i);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
      if (state == S_REQ || state == S_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign err_o = err_q;
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      main_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i) begin
            addr_q  <= roa_i[ADDRESS_WIDTH-1:0];
            wdata_q <= rod_i;
            we_q    <= we_i;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_ready_i) begin
            state <= we_q ? S_DONE : S_WAIT;
          end else if (abort) begin
            state <= S_DONE;
          end
        end
        S_WAIT: begin
          if (bus_rvalid_i) begin
            main_q <= bus_rdata_i;
            state  <= S_DONE;
          end else if (abort) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign bus_valid_o = (state == S_REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign main_o      = main_q;

endmodule

// File: tb/tb_core_mem_port.sv
// Directed self-checking bench for core_mem_port; timeout scenario follows CORE_MEM_TIMEOUT_EN.
module tb_core_mem_port;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        req_i, we_i;
  logic [15:0] roa_i, rod_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] main_o;
  logic        bus_valid_o, bus_ready_i, bus_we_o;
  logic [15:0] bus_addr_o, bus_wdata_o;
  logic        bus_rvalid_i;
  logic [15:0] bus_rdata_i;

  int unsigned errors = 0;
  int unsigned checks = 0;

  core_mem_port #(
    .WORD_WIDTH    (16),
    .ADDRESS_WIDTH (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .roa_i       (roa_i),
    .rod_i       (rod_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .main_o      (main_o),
    .bus_valid_o (bus_valid_o),
    .bus_ready_i (bus_ready_i),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i (bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    arst_n_i = 1'b0; req_i = 1'b0; we_i = 1'b0; roa_i = '0; rod_i = '0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    tick(); tick();
    arst_n_i = 1'b1;
    tick();
    checks++;
    if ({busy_o, done_o, err_o, bus_valid_o, bus_we_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {busy_o, done_o, err_o, bus_valid_o, bus_we_o});
    end
    checks++;
    if ({main_o, bus_addr_o, bus_wdata_o} !== 48'h0) begin
      errors++; $display("FAIL reset_words got=%h exp=0", {main_o, bus_addr_o, bus_wdata_o});
    end
  endtask

  task automatic test_store();
    req_i = 1'b1; we_i = 1'b1; roa_i = 16'h0040; rod_i = 16'hBEEF; bus_ready_i = 1'b1;
    tick();
    req_i = 1'b0; roa_i = 16'hFFFF; rod_i = 16'h0000;
    checks++;
    if ({bus_valid_o, bus_we_o, busy_o, done_o} !== 4'b1110) begin
      errors++; $display("FAIL store_req_flags got=%b exp=1110", {bus_valid_o, bus_we_o, busy_o, done_o});
    end
    checks++;
    if (bus_addr_o !== 16'h0040 || bus_wdata_o !== 16'hBEEF) begin
      errors++; $display("FAIL store_req_bus got=%h/%h exp=0040/beef", bus_addr_o, bus_wdata_o);
    end
    tick();
    bus_ready_i = 1'b0;
    checks++;
    if ({done_o, err_o, bus_valid_o, busy_o} !== 4'b1001) begin
      errors++; $display("FAIL store_done got=%b exp=1001", {done_o, err_o, bus_valid_o, busy_o});
    end
    checks++;
    if (main_o !== 16'h0000) begin
      errors++; $display("FAIL store_main got=%h exp=0000", main_o);
    end
    tick();
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL store_idle got=%b exp=00", {done_o, busy_o});
    end
  endtask

  task automatic test_load_stall();
    req_i = 1'b1; we_i = 1'b0; roa_i = 16'h0123; rod_i = 16'h7777; bus_ready_i = 1'b0;
    tick();
    req_i = 1'b0; roa_i = 16'h0999;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus_valid_o !== 1'b1 || bus_addr_o !== 16'h0123 || bus_we_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++; $display("FAIL load_stall_%0d got=v%b a%h w%b b%b exp=v1 a0123 w0 b1",
                           i, bus_valid_o, bus_addr_o, bus_we_o, busy_o);
      end
      if (i < 2) tick();
    end
    bus_ready_i = 1'b1;
    tick();
    bus_ready_i = 1'b0;
    tick();
    checks++;
    if ({bus_valid_o, busy_o, done_o} !== 3'b010) begin
      errors++; $display("FAIL load_wait got=%b exp=010", {bus_valid_o, busy_o, done_o});
    end
    bus_rvalid_i = 1'b1; bus_rdata_i = 16'h5A5A;
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = 16'hDEAD;
    checks++;
    if (main_o !== 16'h5A5A || done_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL load_done got=main%h d%b b%b exp=main5a5a d1 b1", main_o, done_o, busy_o);
    end
    tick();
    checks++;
    if (main_o !== 16'h5A5A || busy_o !== 1'b0) begin
      errors++; $display("FAIL load_hold got=main%h b%b exp=main5a5a b0", main_o, busy_o);
    end
  endtask

  task automatic test_rvalid_in_req();
    req_i = 1'b1; we_i = 1'b0; roa_i = 16'h0200; bus_ready_i = 1'b1;
    tick();
    req_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 16'h1111;
    tick();
    bus_ready_i = 1'b0;
    checks++;
    if (main_o !== 16'h5A5A || done_o !== 1'b0) begin
      errors++; $display("FAIL rvalid_req_ignored got=main%h d%b exp=main5a5a d0", main_o, done_o);
    end
    bus_rdata_i = 16'h2222;
    tick();
    bus_rvalid_i = 1'b0;
    checks++;
    if (main_o !== 16'h2222 || done_o !== 1'b1) begin
      errors++; $display("FAIL rvalid_wait got=main%h d%b exp=main2222 d1", main_o, done_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int unsigned dones = 0;
    req_i = 1'b1; we_i = 1'b1; roa_i = 16'h0300; rod_i = 16'h0001; bus_ready_i = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (done_o) dones++;
      checks++;
      if (done_o !== ((k % 3) == 2) || bus_valid_o !== ((k % 3) == 1)) begin
        errors++; $display("FAIL b2b_cycle%0d got=d%b v%b exp=d%b v%b", k, done_o, bus_valid_o,
                           (k % 3) == 2, (k % 3) == 1);
      end
    end
    req_i = 1'b0; bus_ready_i = 1'b0;
    checks++;
    if (dones != 3) begin
      errors++; $display("FAIL b2b_count got=%0d exp=3", dones);
    end
    tick(); tick();
    checks++;
    if (busy_o !== 1'b0 || main_o !== 16'h2222) begin
      errors++; $display("FAIL b2b_idle got=b%b main%h exp=b0 main2222", busy_o, main_o);
    end
  endtask

  task automatic test_timeout();
    req_i = 1'b1; we_i = 1'b0; roa_i = 16'h0400; bus_ready_i = 1'b0;
    tick();
    req_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (bus_valid_o !== 1'b1 || err_o !== 1'b0 || done_o !== 1'b0) begin
        errors++; $display("FAIL timeout_req%0d got=v%b e%b d%b exp=v1 e0 d0", k, bus_valid_o, err_o, done_o);
      end
      tick();
    end
`ifdef CORE_MEM_TIMEOUT_EN
    checks++;
    if ({bus_valid_o, done_o, err_o, busy_o} !== 4'b0111 || main_o !== 16'h2222) begin
      errors++; $display("FAIL timeout_abort got=v%b d%b e%b b%b main%h exp=v0 d1 e1 b1 main2222",
                         bus_valid_o, done_o, err_o, busy_o, main_o);
    end
    tick();
    checks++;
    if ({busy_o, done_o, err_o} !== 3'b000) begin
      errors++; $display("FAIL timeout_idle got=%b exp=000", {busy_o, done_o, err_o});
    end
`else
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus_valid_o !== 1'b1 || err_o !== 1'b0 || done_o !== 1'b0) begin
        errors++; $display("FAIL no_timeout%0d got=v%b e%b d%b exp=v1 e0 d0", k, bus_valid_o, err_o, done_o);
      end
      tick();
    end
    bus_ready_i = 1'b1;
    tick();
    bus_ready_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 16'h3333;
    tick();
    bus_rvalid_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || main_o !== 16'h3333) begin
      errors++; $display("FAIL no_timeout_done got=d%b e%b main%h exp=d1 e0 main3333", done_o, err_o, main_o);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid_load();
    req_i = 1'b1; we_i = 1'b0; roa_i = 16'h0555; bus_ready_i = 1'b1;
    tick();
    req_i = 1'b0;
    tick();
    bus_ready_i = 1'b0;
    checks++;
    if ({busy_o, bus_valid_o, done_o} !== 3'b100) begin
      errors++; $display("FAIL mid_load_wait got=%b exp=100", {busy_o, bus_valid_o, done_o});
    end
    #2 arst_n_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, bus_valid_o, bus_we_o} !== 5'b0 ||
        {main_o, bus_addr_o, bus_wdata_o} !== 48'h0) begin
      errors++; $display("FAIL mid_load_reset got=%b main%h a%h w%h exp=all zero",
                         {busy_o, done_o, err_o, bus_valid_o, bus_we_o}, main_o, bus_addr_o, bus_wdata_o);
    end
    bus_rvalid_i = 1'b1; bus_rdata_i = 16'h4444;
    tick();
    arst_n_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({busy_o, done_o} !== 2'b00 || main_o !== 16'h0000) begin
        errors++; $display("FAIL post_reset%0d got=b%b d%b main%h exp=b0 d0 main0000", k, busy_o, done_o, main_o);
      end
    end
    bus_rvalid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_stall();
    test_rvalid_in_req();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
